instr_loader: RTL



---
 rtl/instr_loader_if.sv | 30 +++
 rtl/instr_loader.sv | 107 ++++++++++
 2 files changed

// File: rtl/instr_loader_if.sv
// Byte-stream and memory-write bundle between the host and instr_loader.
// Handshake: a byte moves on a rising edge where byte_valid && byte_ready
// are both high. The host holds byte_in stable while byte_valid is high
// and byte_ready is low. byte_ready never depends on byte_valid.
interface instr_loader_if #(
  parameter int INSTR_W = 13,
  parameter int ADDR_W  = 8
);
  logic [7:0]         byte_in;
  logic               byte_valid;
  logic               byte_ready;
  logic               load_req;
  logic [INSTR_W-1:0] instruction;
  logic [ADDR_W-1:0]  i;
  logic               start;
  logic [ADDR_W-1:0]  prog_len;
  logic               error;

  // Host / testbench side
  modport master (
    output byte_in, byte_valid, load_req,
    input  byte_ready, instruction, i, start, prog_len, error
  );

  // Loader side
  modport slave (
    input  byte_in, byte_valid, load_req,
    output byte_ready, instruction, i, start, prog_len, error
  );
endinterface

// File: rtl/instr_loader.sv
// instr_loader: packs a high/low byte stream into 13-bit instructions and
// drives the instruction memory write port (instruction, i, start). The
// memory writes every cycle while start=0, so instruction/i change only on
// a commit and hold otherwise. start rises after a one-cycle flush that
// lets the memory capture the final word, and drops on load_req.
module instr_loader #(
  parameter int INSTR_W = 13,
  parameter int ADDR_W  = 8,
  parameter int DEPTH   = 101
) (
  input  logic         clk,
  input  logic         reset,
  instr_loader_if.slave bus,
  output logic [2:0]   dbg_state
);

  localparam logic [2:0] S_LOAD_HI = 3'd0;
  localparam logic [2:0] S_LOAD_LO = 3'd1;
  localparam logic [2:0] S_FLUSH   = 3'd2;
  localparam logic [2:0] S_RUN     = 3'd3;
  localparam logic [2:0] S_ERROR   = 3'd4;

  logic [2:0]         r_state;
  logic               r_last;
  logic [4:0]         r_hi5;
  logic [ADDR_W-1:0]  r_count;
  logic [INSTR_W-1:0] r_instr;
  logic [ADDR_W-1:0]  r_i;
  logic               r_start;
  logic               r_error;

  logic               w_ready;
  logic               w_xfer;

  // Ready only in the two loading states, and never in a load_req cycle
  always_comb begin
    w_ready = 1'b0;
    if ((r_state == S_LOAD_HI) || (r_state == S_LOAD_LO))
      w_ready = !bus.load_req;
  end

  assign w_xfer = w_ready && bus.byte_valid;

  // Loader state machine, byte packing and memory-port registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_LOAD_HI;
      r_last  <= 1'b0;
      r_hi5   <= '0;
      r_count <= '0;
      r_instr <= '0;
      r_i     <= '0;
      r_start <= 1'b0;
      r_error <= 1'b0;
    end else if (bus.load_req) begin
      // Restart: drop any pending high byte, keep instruction/i as they are
      r_state <= S_LOAD_HI;
      r_last  <= 1'b0;
      r_hi5   <= '0;
      r_count <= '0;
      r_start <= 1'b0;
      r_error <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD_HI: begin
          if (w_xfer) begin
            r_last  <= bus.byte_in[7];
            r_hi5   <= bus.byte_in[4:0];
            r_state <= S_LOAD_LO;
          end
        end
        S_LOAD_LO: begin
          if (w_xfer) begin
            r_instr <= INSTR_W'({r_hi5, bus.byte_in});
            r_i     <= r_count;
            r_count <= r_count + 1'b1;
            if (r_last) begin
              r_state <= S_FLUSH;
            end else if (r_count == ADDR_W'(DEPTH - 1)) begin
              r_state <= S_ERROR;
              r_error <= 1'b1;
            end else begin
              r_state <= S_LOAD_HI;
            end
          end
        end
        S_FLUSH: begin
          // Final word sits on the port for one write edge with start=0
          r_state <= S_RUN;
          r_start <= 1'b1;
        end
        S_RUN:   r_state <= S_RUN;
        S_ERROR: r_state <= S_ERROR;
        default: r_state <= S_LOAD_HI;
      endcase
    end
  end

  assign bus.byte_ready  = w_ready;
  assign bus.instruction = r_instr;
  assign bus.i           = r_i;
  assign bus.start       = r_start;
  assign bus.prog_len    = r_count;
  assign bus.error       = r_error;
  assign dbg_state       = r_state;

endmodule
